// File: rtl/mem_a.sv
`default_nettype none
// ============================================================================
//  Module   : mem_a
//  Purpose  : Systolic A-matrix feeder. It holds DIM rows and drains them as a
//             skewed stream, where lane r lags lane 0 by r cycles.
//  Option   : MEM_A_ASSERT_EN enables simulation-only protocol checks.
//  Revision : 1.0  initial release
// ============================================================================
module mem_a #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain  [DIM-1:0],
  input  logic [$clog2(DIM)-1:0]    Arow,
  output logic signed [BITS_AB-1:0] Aout [DIM-1:0]
);

  logic signed [BITS_AB-1:0] a_q [DIM-1:0][DIM-1:0];
  logic signed [BITS_AB-1:0] a_d [DIM-1:0][DIM-1:0];
  logic                      shift_en;

  // A write wins over a shift that happens on the same edge.
  assign shift_en = en & ~WrEn;

  always_comb begin
    a_d = a_q;
    if (WrEn) begin
      a_d[Arow] = Ain;
    end else if (en) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM - 1; c++) begin
          a_d[r][c] = a_q[r][c+1];
        end
        a_d[r][DIM-1] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_q[r][c] <= '0;
        end
      end
    end else begin
      a_q <= a_d;
    end
  end

  assign Aout[0] = a_q[0][0];

  // Lane r owns an r-deep delay chain that is fed by the head of row r.
  for (genvar r = 1; r < DIM; r++) begin : g_lane
    logic signed [BITS_AB-1:0] dly_q [r-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < r; k++) begin
          dly_q[k] <= '0;
        end
      end else if (shift_en) begin
        dly_q[0] <= a_q[r][0];
        for (int k = 1; k < r; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end

    assign Aout[r] = dly_q[r-1];
  end

`ifdef MEM_A_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({WrEn, en, Arow}))
        else $error("mem_a: X/Z on WrEn, en or Arow");
      assert (!(WrEn && en))
        else $error("mem_a: WrEn and en asserted together");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_a.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_a
//  Purpose  : Directed self-checking bench for mem_a (DIM=8, BITS_AB=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_a;

  localparam int DIM  = 8;
  localparam int BITS = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   en;
  logic                   WrEn;
  logic signed [BITS-1:0] Ain  [DIM-1:0];
  logic [2:0]             Arow;
  logic signed [BITS-1:0] Aout [DIM-1:0];

  int n_pass  = 0;
  int n_total = 0;

  logic signed [BITS-1:0] mdl [DIM][DIM];

  mem_a #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .WrEn (WrEn),
    .Ain  (Ain),
    .Arow (Arow),
    .Aout (Aout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  // Expected lane r after n shift edges from a fresh load.
  function automatic logic [BITS-1:0] exp_lane(int r, int n);
    int k;
    k = n - r;
    if (k >= 0 && k < DIM) return mdl[r][k];
    return '0;
  endfunction

  task automatic check_lanes(input string tag, input int n);
    for (int r = 0; r < DIM; r++)
      check($sformatf("%s n%0d lane%0d", tag, n, r), Aout[r], exp_lane(r, n));
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < DIM; r++)
      check($sformatf("%s lane%0d", tag, r), Aout[r], '0);
  endtask

  task automatic set_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mdl[r][c] = BITS'(10 * r + c + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int r = 0; r < DIM; r++) begin
      Arow = 3'(r);
      for (int c = 0; c < DIM; c++) Ain[c] = mdl[r][c];
      WrEn = 1'b1;
      tick();
    end
    WrEn = 1'b0;
  endtask

  task automatic drain(input string tag, input int from_n, input int to_n);
    for (int n = from_n; n <= to_n; n++) begin
      en = 1'b1;
      tick();
      check_lanes(tag, n);
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    WrEn  = 1'b0;
    Arow  = '0;
    for (int c = 0; c < DIM; c++) Ain[c] = '0;

    // Asynchronous reset: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Load and idle.
    set_model();
    load_all();
    tick();
    tick();
    check_lanes("idle", 0);

    // Drain with a 4-cycle hold after edge 5.
    drain("drain", 1, 5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_lanes("hold", 5);
    end
    drain("resume", 6, 15);

    // Write priority over shift.
    load_all();
    Arow = 3'd2;
    for (int c = 0; c < DIM; c++) Ain[c] = -8'sd128;
    WrEn = 1'b1;
    en   = 1'b1;
    tick();
    WrEn = 1'b0;
    en   = 1'b0;
    for (int c = 0; c < DIM; c++) mdl[2][c] = -8'sd128;
    check_lanes("prio", 0);
    drain("prio_drain", 1, 15);

    // Reset mid-drain.
    set_model();
    load_all();
    drain("pre_rst", 1, 6);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      tick();
      check_zero($sformatf("post_rst%0d", i));
    end
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_a.md
MEM_A -- requirements
Module: mem_a

Interface
REQ-001 Parameter BITS_AB, default 8, SHALL set the signed element width in bits.
REQ-002 Parameter DIM, default 8, SHALL set the matrix dimension (rows, columns, output lanes); legal values are powers of two, 2 or greater.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the drain/shift enable.
REQ-006 WrEn  input  1  SHALL be the row write enable.
REQ-007 Ain  input  DIM x BITS_AB signed (unpacked [DIM-1:0])  SHALL carry the row data; Ain[c] is the column c element.
REQ-008 Arow  input  $clog2(DIM)  SHALL be the row index written when WrEn=1.
REQ-009 Aout  output  DIM x BITS_AB (unpacked [DIM-1:0])  SHALL carry the skewed systolic feed; Aout[r] is lane r.

Function
REQ-010 Storage: DIM row buffers of DIM elements each (A[r][0..DIM-1]), plus a skew delay chain of r registers for lane r (lane 0 has none), for DIM*(DIM-1)/2 delay registers in total.
REQ-011 Write: on a clock edge with WrEn=1, A[Arow][c] SHALL take Ain[c] for all c; other rows are unchanged, and the delay chains and the other rows do not shift.
REQ-012 Shift: on a clock edge with WrEn=0 and en=1, each row buffer SHALL shift one element toward index 0 (element 0 leaves, tail fills with 0).
REQ-013 On the same shift edge, the element leaving row r SHALL enter the delay chain of lane r, and every delay chain SHALL advance by one stage.
REQ-014 Aout[0] SHALL be combinational from A[0][0]; for r>0, Aout[r] SHALL be the last stage of lane r's delay chain.
REQ-015 Timing: after a load, with chains at zero and n shift edges, Aout[r] SHALL equal the original A[r][n-r] when 0 <= n-r < DIM, and 0 otherwise.
REQ-016 A full drain SHALL take 2*DIM-1 shift edges; after that, all Aout SHALL be 0.
REQ-017 With WrEn=0 and en=0, all state SHALL hold.
REQ-018 Simultaneous WrEn=1 and en=1: the write SHALL take priority, and no shift occurs on that edge.
REQ-019 Data SHALL be stored and output bit-exact, with no sign extension or saturation; the range is -2^(BITS_AB-1) .. 2^(BITS_AB-1)-1.
REQ-020 The block SHALL accept one write per cycle, with a new row on every consecutive WrEn cycle.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear all row buffers and delay registers to 0, so all Aout read 0, including mid-drain.
REQ-022 After rst_n is released, the first active edge SHALL behave as in REQ-011 to REQ-017.

Configuration
REQ-023 Macro MEM_A_ASSERT_EN: when defined, simulation assertions SHALL report an error on any clock edge where WrEn and en are both 1, or where WrEn, en or Arow is X/Z while rst_n=1.
REQ-024 Without MEM_A_ASSERT_EN, no checks SHALL be compiled.
REQ-025 Functional behaviour SHALL be identical with and without MEM_A_ASSERT_EN.

Verification (DIM=8, BITS_AB=8, A[r][c]=10*r+c+1)
REQ-026 Reset: pulse rst_n low with en=WrEn=0 -> all Aout=0, immediately and without waiting for a clock.
REQ-027 Load rows 0..7 on consecutive edges, then idle 2 cycles -> Aout[0]=1, Aout[1..7]=0, stable.
REQ-028 Drain with en=1: after 3 edges -> Aout[0]=4, Aout[1]=13, Aout[2]=22, Aout[3]=31, Aout[4..7]=0; after 14 edges -> Aout[7]=78, others 0; after 15 edges -> all 0.
REQ-029 Hold: drop en for 4 cycles after edge 5 -> Aout stays at its edge-5 values (Aout[0]=6, Aout[5]=51); resuming continues the sequence.
REQ-030 Write priority: with WrEn=1, Arow=2, Ain all -128 and en=1 on the same edge -> row 2 becomes -128 (0x80) and no lane shifts.
REQ-031 Reset mid-drain: assert rst_n=0 after edge 6 -> all Aout=0; a subsequent en=1 with no load keeps all Aout=0.
